fog_step_integrator: RTL and testbench

- Closed-loop feedback stage directly downstream of the FOG error-signal generator.
- Consumes the demodulated error word and its sync pulse, and scales the error by a programmable right shift.
- Integrates the scaled error into a saturating rate register (the gyro rate output), then integrates the rate into a wrapping phase-step accumulator (the digital serrodyne ramp).
- Sums the ramp with the square-wave modulation word to form the phase-modulator DAC word.

---
 rtl/fog_pkg.sv | 15 +
 rtl/fog_sat_add.sv | 28 ++
 rtl/fog_step_integrator.sv | 99 +++++++++
 tb/tb_fog_step_integrator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fog_pkg.sv
// Shared definitions for the FOG closed-loop feedback stages.
package fog_pkg;

    localparam int unsigned ERR_W_DEF    = 32;
    localparam int unsigned GAIN_W_DEF   = 5;
    localparam logic [31:0] RATE_LIM_DEF = 32'h3FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_INTEG = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

endpackage

// File: rtl/fog_sat_add.sv
// Signed add with one guard bit, clamped symmetrically to +/-LIM.
module fog_sat_add #(
    parameter int unsigned     W   = 32,
    parameter logic [W-1:0]    LIM = {1'b0, {(W-1){1'b1}}}
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum
);

    logic signed [W:0] w_sum;
    logic signed [W:0] w_pos_lim;
    logic signed [W:0] w_neg_lim;

    assign w_sum     = $signed({i_a[W-1], i_a}) + $signed({i_b[W-1], i_b});
    assign w_pos_lim = $signed({1'b0, LIM});
    assign w_neg_lim = -w_pos_lim;

    always_comb begin
        o_sum = w_sum[W-1:0];
        if (w_sum > w_pos_lim) begin
            o_sum = w_pos_lim[W-1:0];
        end else if (w_sum < w_neg_lim) begin
            o_sum = w_neg_lim[W-1:0];
        end
    end

endmodule

// File: rtl/fog_step_integrator.sv
// Error -> saturating rate -> wrapping phase-step ramp, plus modulation sum for the DAC.
module fog_step_integrator
    import fog_pkg::*;
#(
    parameter int unsigned      ERR_W    = ERR_W_DEF,
    parameter int unsigned      GAIN_W   = GAIN_W_DEF,
    parameter logic [ERR_W-1:0] RATE_LIM = ERR_W'(RATE_LIM_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ERR_W-1:0]  i_err,
    input  logic              i_sync,
    input  logic [GAIN_W-1:0] i_gain_sel,
    input  logic              i_loop_en,
    input  logic [ERR_W-1:0]  i_const_rate,
    input  logic [ERR_W-1:0]  i_mod_in,
    output logic [ERR_W-1:0]  o_rate,
    output logic [ERR_W-1:0]  o_step,
    output logic [ERR_W-1:0]  o_phase_out,
    output logic              o_step_valid,
    output logic              o_overrun,
    output logic [1:0]        o_state
);

    state_e                    r_state;
    logic signed [ERR_W-1:0]   r_err;
    logic [GAIN_W-1:0]         r_gain;
    logic                      r_loop_en;
    logic signed [ERR_W-1:0]   r_scaled;
    logic signed [ERR_W-1:0]   r_rate;
    logic [ERR_W-1:0]          r_step;
    logic [ERR_W-1:0]          r_phase;
    logic                      r_valid;
    logic                      r_overrun;
    logic signed [ERR_W-1:0]   w_rate_sum;

    fog_sat_add #(
        .W   (ERR_W),
        .LIM (RATE_LIM)
    ) u_sat_add (
        .i_a   (r_rate),
        .i_b   (r_scaled),
        .o_sum (w_rate_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_err     <= '0;
            r_gain    <= '0;
            r_loop_en <= 1'b0;
            r_scaled  <= '0;
            r_rate    <= '0;
            r_step    <= '0;
            r_phase   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_phase <= r_step + i_mod_in;
            if (i_sync && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_sync) begin
                        r_err     <= i_err;
                        r_gain    <= i_gain_sel;
                        r_loop_en <= i_loop_en;
                        r_state   <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    // Arithmetic shift floors negative values (-1 >>> n stays -1).
                    r_scaled <= r_err >>> r_gain;
                    r_state  <= ST_INTEG;
                end
                ST_INTEG: begin
                    r_rate  <= r_loop_en ? w_rate_sum : i_const_rate;
                    r_state <= ST_STEP;
                end
                ST_STEP: begin
                    r_step  <= r_step + r_rate;
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rate       = r_rate;
    assign o_step       = r_step;
    assign o_phase_out  = r_phase;
    assign o_step_valid = r_valid;
    assign o_overrun    = r_overrun;
    assign o_state      = r_state;

endmodule

// File: tb/tb_fog_step_integrator.sv
// Directed bench for fog_step_integrator: latency, saturation, wrap, overrun, reset abort.
module tb_fog_step_integrator;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_err;
    logic        i_sync;
    logic [4:0]  i_gain_sel;
    logic        i_loop_en;
    logic [31:0] i_const_rate;
    logic [31:0] i_mod_in;
    logic [31:0] o_rate;
    logic [31:0] o_step;
    logic [31:0] o_phase_out;
    logic        o_step_valid;
    logic        o_overrun;
    logic [1:0]  o_state;

    int n_tests = 0;
    int n_fail  = 0;

    fog_step_integrator dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_err        (i_err),
        .i_sync       (i_sync),
        .i_gain_sel   (i_gain_sel),
        .i_loop_en    (i_loop_en),
        .i_const_rate (i_const_rate),
        .i_mod_in     (i_mod_in),
        .o_rate       (o_rate),
        .o_step       (o_step),
        .o_phase_out  (o_phase_out),
        .o_step_valid (o_step_valid),
        .o_overrun    (o_overrun),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Returns in cycle N+1 of a sync issued in the current cycle N.
    task automatic do_sync(input logic [31:0] err, input logic [4:0] gain, input logic en);
        i_err      = err;
        i_gain_sel = gain;
        i_loop_en  = en;
        i_sync     = 1'b1;
        tick(1);
        i_sync     = 1'b0;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        tick(2);
        i_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        i_mod_in = 32'h0;
        apply_reset();
        tick(100);
        n_tests++;
        if ({o_rate, o_step, o_phase_out} !== 96'h0) begin
            $display("FAIL reset_words: rate=%0h step=%0h phase=%0h exp 0", o_rate, o_step,
                     o_phase_out);
            n_fail++;
        end
        n_tests++;
        if ({o_step_valid, o_overrun, o_state} !== 4'h0) begin
            $display("FAIL reset_flags: valid=%0b ovr=%0b state=%0d exp 0", o_step_valid,
                     o_overrun, o_state);
            n_fail++;
        end
        i_mod_in = 32'h100;
        tick(1);
        n_tests++;
        if (o_phase_out !== 32'h100) begin
            $display("FAIL reset_phase: got %0h exp 100", o_phase_out);
            n_fail++;
        end
        i_mod_in = 32'h0;
        tick(1);
    endtask

    task automatic test_closed_loop();
        int expr[2] = '{100, 200};
        int exps[2] = '{100, 300};
        for (int k = 0; k < 2; k++) begin
            do_sync(32'd400, 5'd2, 1'b1);
            tick(2);
            n_tests++;
            if (o_rate !== 32'(expr[k])) begin
                $display("FAIL cl_rate%0d: got %0d exp %0d", k, o_rate, expr[k]);
                n_fail++;
            end
            tick(1);
            n_tests++;
            if (o_step !== 32'(exps[k]) || o_step_valid !== 1'b1) begin
                $display("FAIL cl_step%0d: step=%0d valid=%0b exp %0d/1", k, o_step,
                         o_step_valid, exps[k]);
                n_fail++;
            end
            i_mod_in = 32'd5;
            tick(1);
            n_tests++;
            if (o_step_valid !== 1'b0) begin
                $display("FAIL cl_valid_width%0d: valid=%0b exp 0", k, o_step_valid);
                n_fail++;
            end
            n_tests++;
            if (o_phase_out !== 32'(exps[k] + 5)) begin
                $display("FAIL cl_phase%0d: got %0d exp %0d", k, o_phase_out, exps[k] + 5);
                n_fail++;
            end
            i_mod_in = 32'h0;
        end
    endtask

    // Continues from rate=200, step=300.
    task automatic test_neg_shift();
        do_sync(32'hFFFF_FFFF, 5'd4, 1'b1);
        tick(3);
        n_tests++;
        if (o_rate !== 32'd199 || o_step !== 32'd499) begin
            $display("FAIL neg_shift: rate=%0d step=%0d exp 199/499", o_rate, o_step);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            do_sync(32'h4000_0000, 5'd0, 1'b1);
            tick(3);
            n_tests++;
            if (o_rate !== 32'h3FFF_FFFF) begin
                $display("FAIL sat_pos%0d: got %0h exp 3fffffff", k, o_rate);
                n_fail++;
            end
        end
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            do_sync(32'hC000_0000, 5'd0, 1'b1);
            tick(3);
            n_tests++;
            if (o_rate !== 32'hC000_0001) begin
                $display("FAIL sat_neg%0d: got %0h exp c0000001", k, o_rate);
                n_fail++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exps[3] = '{32'h8000_0000, 32'h0, 32'h8000_0000};
        apply_reset();
        i_const_rate = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            do_sync(32'd12345, 5'd0, 1'b0);
            tick(3);
            n_tests++;
            if (o_rate !== 32'h8000_0000 || o_step !== exps[k]) begin
                $display("FAIL wrap%0d: rate=%0h step=%0h exp 80000000/%0h", k, o_rate,
                         o_step, exps[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_loop_switch();
        apply_reset();
        i_const_rate = 32'd1000;
        do_sync(32'd0, 5'd0, 1'b0);
        tick(3);
        // Closed loop resumes from 1000; loop_en flips mid-sequence and must be ignored.
        do_sync(32'd8, 5'd3, 1'b1);
        i_loop_en = 1'b0;
        tick(3);
        n_tests++;
        if (o_rate !== 32'd1001 || o_step !== 32'd2001) begin
            $display("FAIL loop_switch: rate=%0d step=%0d exp 1001/2001", o_rate, o_step);
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        apply_reset();
        do_sync(32'd400, 5'd2, 1'b1);
        tick(1);
        i_sync = 1'b1;
        tick(1);
        i_sync = 1'b0;
        n_tests++;
        if (o_rate !== 32'd100 || o_overrun !== 1'b1) begin
            $display("FAIL ovr_rate: rate=%0d ovr=%0b exp 100/1", o_rate, o_overrun);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (o_step_valid === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 1 || o_step !== 32'd100 || o_rate !== 32'd100) begin
            $display("FAIL ovr_single: pulses=%0d step=%0d rate=%0d exp 1/100/100", pulses,
                     o_step, o_rate);
            n_fail++;
        end
        n_tests++;
        if (o_overrun !== 1'b1) begin
            $display("FAIL ovr_sticky: got %0b exp 1", o_overrun);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_sync(32'd400, 5'd2, 1'b1);
        tick(3);
        do_sync(32'd400, 5'd2, 1'b1);
        tick(2);
        n_tests++;
        if (o_rate !== 32'd200) begin
            $display("FAIL b2b_rate: got %0d exp 200", o_rate);
            n_fail++;
        end
        tick(1);
        n_tests++;
        if (o_step !== 32'd300 || o_step_valid !== 1'b1 || o_overrun !== 1'b0) begin
            $display("FAIL b2b_step: step=%0d valid=%0b ovr=%0b exp 300/1/0", o_step,
                     o_step_valid, o_overrun);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        apply_reset();
        do_sync(32'd400, 5'd2, 1'b1);
        tick(1);
        i_rst_n = 1'b0;
        i_sync  = 1'b1;
        #1;
        n_tests++;
        if ({o_rate, o_step, o_phase_out} !== 96'h0 || o_state !== 2'd0) begin
            $display("FAIL rst_mid_out: rate=%0d step=%0d phase=%0d state=%0d exp 0", o_rate,
                     o_step, o_phase_out, o_state);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (o_step_valid !== 1'b0 || o_state !== 2'd0) pulses++;
        end
        i_sync  = 1'b0;
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (o_step_valid !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            $display("FAIL rst_mid_quiet: %0d bad cycles exp 0", pulses);
            n_fail++;
        end
        do_sync(32'd400, 5'd2, 1'b1);
        tick(3);
        n_tests++;
        if (o_rate !== 32'd100 || o_step !== 32'd100 || o_step_valid !== 1'b1) begin
            $display("FAIL rst_mid_resume: rate=%0d step=%0d valid=%0b exp 100/100/1", o_rate,
                     o_step, o_step_valid);
            n_fail++;
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_err        = 32'h0;
        i_sync       = 1'b0;
        i_gain_sel   = 5'd0;
        i_loop_en    = 1'b1;
        i_const_rate = 32'h0;
        i_mod_in     = 32'h0;
        test_reset();
        test_closed_loop();
        test_neg_shift();
        test_saturation();
        test_wrap();
        test_loop_switch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
